// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: synchronise and glitch-filter the raw pins, deframe 11-bit frames into byte strobes.
// Optional break-code folding (0xF0 prefix sets brk on the next byte) is enabled by defining PS2_RX_BREAK_DECODE_EN.
module ps2_receiver #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       not_rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic       brk
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // bit 0 = clock line, bit 1 = data line
    logic [1:0] raw;
    logic [1:0] filt;
    assign raw = {ps2_dat, ps2_clk};

    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        logic          sync1_reg;
        logic          sync2_reg;
        logic          filt_reg;
        logic [FW-1:0] cnt_reg;

        always_ff @(posedge clk or negedge not_rst) begin
            if (!not_rst) begin
                sync1_reg <= 1'b1;
                sync2_reg <= 1'b1;
                filt_reg  <= 1'b1;
                cnt_reg   <= FW'(1);
            end else begin
                sync1_reg <= raw[gi];
                sync2_reg <= sync1_reg;
                if (sync2_reg == filt_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == FW'(FILTER_LEN - 1)) begin
                    filt_reg <= sync2_reg;
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + FW'(1);
                end
            end
        end

        assign filt[gi] = filt_reg;
    end

    logic          clk_prev_reg;
    logic          fall;
    state_t        state_reg, state_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          parity_reg, parity_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic [7:0]    data_reg, data_next;
    logic          valid_reg, valid_next;
    logic          err_reg, err_next;
    logic          frame_good;

    assign fall       = clk_prev_reg & ~filt[0];
    assign frame_good = filt[1] & (^{shift_reg, parity_reg});

`ifdef PS2_RX_BREAK_DECODE_EN
    logic pend_reg, pend_next;
    logic brk_reg, brk_next;
`endif

    always_ff @(posedge clk or negedge not_rst) begin
        if (!not_rst) begin
            clk_prev_reg <= 1'b1;
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            to_cnt_reg   <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
`ifdef PS2_RX_BREAK_DECODE_EN
            pend_reg     <= 1'b0;
            brk_reg      <= 1'b0;
`endif
        end else begin
            clk_prev_reg <= filt[0];
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            to_cnt_reg   <= to_cnt_next;
            data_reg     <= data_next;
            valid_reg    <= valid_next;
            err_reg      <= err_next;
`ifdef PS2_RX_BREAK_DECODE_EN
            pend_reg     <= pend_next;
            brk_reg      <= brk_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        to_cnt_next  = (state_reg == IDLE || fall) ? '0 : to_cnt_reg + TW'(1);
`ifdef PS2_RX_BREAK_DECODE_EN
        pend_next    = pend_reg;
        brk_next     = brk_reg;
`endif
        if (fall) begin
            case (state_reg)
                IDLE: begin
                    if (!filt[1]) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shift_next   = {filt[1], shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) state_next = PARITY;
                end
                PARITY: begin
                    parity_next = filt[1];
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (frame_good) begin
`ifdef PS2_RX_BREAK_DECODE_EN
                        if (shift_reg == 8'hF0) begin
                            pend_next = 1'b1;
                        end else begin
                            valid_next = 1'b1;
                            data_next  = shift_reg;
                            // an extended-code prefix passes through and keeps any pending break
                            if (shift_reg == 8'hE0) begin
                                brk_next = 1'b0;
                            end else begin
                                brk_next  = pend_reg;
                                pend_next = 1'b0;
                            end
                        end
`else
                        valid_next = 1'b1;
                        data_next  = shift_reg;
`endif
                    end else begin
                        err_next = 1'b1;
`ifdef PS2_RX_BREAK_DECODE_EN
                        pend_next = 1'b0;
`endif
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (state_reg != IDLE && to_cnt_reg == TW'(TIMEOUT_CYC)) begin
            err_next    = 1'b1;
            state_next  = IDLE;
            to_cnt_next = '0;
`ifdef PS2_RX_BREAK_DECODE_EN
            pend_next   = 1'b0;
`endif
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;
    assign err   = err_reg;
`ifdef PS2_RX_BREAK_DECODE_EN
    assign brk   = brk_reg;
`else
    assign brk   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: clean/parity/stop/timeout/glitch/break/reset frames with hand-computed expectations.
// PS/2 clock runs at a scaled-down rate and the timeout is shortened to keep the run brief.
module tb_ps2_receiver;
    localparam int H  = 24;   // PS/2 half-period in clk cycles (>= FILTER_LEN + 4)
    localparam int TO = 600;

    logic       clk = 1'b0;
    logic       not_rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] data;
    logic       valid, err, brk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0, n_err = 0, n_both = 0;
    int valid_cyc = 0, fall_cyc = 0;
    logic [7:0] last_data = 8'h00, prev_data = 8'h00;
    logic       last_brk = 1'b0;
    int v0, e0;

    ps2_receiver #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .not_rst(not_rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .data(data), .valid(valid), .err(err), .brk(brk)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            prev_data = last_data;
            last_data = data;
            last_brk  = brk;
            valid_cyc = cyc;
        end
        if (err) n_err++;
        if (valid && err) n_both++;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish, required finish before 10ms");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit glitch, input bit is_stop);
        ps2_dat = b;
        wait_cyc(H / 2);
        ps2_clk = 1'b0;
        if (is_stop) fall_cyc = cyc;
        wait_cyc(H);
        ps2_clk = 1'b1;
        wait_cyc(H / 2);
        if (glitch) begin
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
        end
        wait_cyc(H / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {stop, par, b, 1'b0};
        v0 = n_valid;
        e0 = n_err;
        for (int i = 0; i < nbits; i++)
            send_bit(f[i], i == glitch_bit, i == 10);
        ps2_dat = 1'b1;
        wait_cyc(40);
    endtask

    initial begin
        wait_cyc(3);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_brk", {31'd0, brk}, 32'd0);
        not_rst = 1'b1;
        wait_cyc(20);

        // clean 0x1C, parity 0
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        check("clean_valid_cnt", n_valid - v0, 1);
        check("clean_err_cnt", n_err - e0, 0);
        check("clean_data", {24'd0, last_data}, 32'h1C);
        check("clean_brk", {31'd0, last_brk}, 32'd0);
        check("clean_latency", valid_cyc - fall_cyc, 11);

        // parity error
        send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
        check("par_err_cnt", n_err - e0, 1);
        check("par_valid_cnt", n_valid - v0, 0);
        check("par_data_held", {24'd0, data}, 32'h1C);

        // stop error then good 0x5A (parity 1)
        send_frame(8'h5A, 1'b1, 1'b0, 11, -1);
        check("stop_err_cnt", n_err - e0, 1);
        check("stop_valid_cnt", n_valid - v0, 0);
        send_frame(8'h5A, 1'b1, 1'b1, 11, -1);
        check("after_stop_valid_cnt", n_valid - v0, 1);
        check("after_stop_data", {24'd0, data}, 32'h5A);

        // timeout after start + 4 data bits
        send_frame(8'h29, 1'b0, 1'b1, 5, -1);
        wait_cyc(TO + 40);
        check("timeout_err_cnt", n_err - e0, 1);
        check("timeout_valid_cnt", n_valid - v0, 0);
        send_frame(8'h29, 1'b0, 1'b1, 11, -1);
        check("after_to_valid_cnt", n_valid - v0, 1);
        check("after_to_data", {24'd0, data}, 32'h29);

        // 3-cycle glitch on clock during data bit 3
        send_frame(8'h1C, 1'b0, 1'b1, 11, 4);
        check("glitch_valid_cnt", n_valid - v0, 1);
        check("glitch_err_cnt", n_err - e0, 0);
        check("glitch_data", {24'd0, data}, 32'h1C);

        // break sequence 0xF0 (parity 1), 0x1C (parity 0)
        send_frame(8'hF0, 1'b1, 1'b1, 11, -1);
        e0 = n_err;
        v0 = n_valid;
        begin
            int vb;
            vb = v0;
            send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
`ifdef PS2_RX_BREAK_DECODE_EN
            check("brk_valid_cnt", n_valid - vb, 1);
            check("brk_flag", {31'd0, last_brk}, 32'd1);
`else
            check("brk_valid_cnt", n_valid - vb + 1, 2);
            check("brk_first_data", {24'd0, prev_data}, 32'hF0);
            check("brk_flag", {31'd0, last_brk}, 32'd0);
`endif
            check("brk_data", {24'd0, last_data}, 32'h1C);
        end

        // reset in the middle of a frame
        send_frame(8'h33, 1'b0, 1'b1, 4, -1);
        not_rst = 1'b0;
        wait_cyc(3);
        not_rst = 1'b1;
        wait_cyc(TO + 40);
        check("midrst_valid_cnt", n_valid - v0, 0);
        check("midrst_err_cnt", n_err - e0, 0);
        check("midrst_data", {24'd0, data}, 32'h00);

        check("valid_err_overlap", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
